// File: rtl/htd_frame_rx.sv
// Frame receiver: validates head/tail flags, buffers frames in a packet FIFO,
// commits good frames atomically and replays them over a valid/ready stream.
module htd_frame_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH:0]   iv_data,
  input  logic                  i_data_wr,
  output logic [DATA_WIDTH-1:0] ov_data,
  output logic                  o_data_valid,
  output logic                  o_data_last,
  input  logic                  i_data_ready,
  output logic [CNT_WIDTH-1:0]  ov_frame_cnt,
  output logic [CNT_WIDTH-1:0]  ov_drop_cnt,
  output logic                  o_drop_pulse
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {S_SKIP, S_IDLE, S_RECV, S_DROP} state_t;

  state_t r_state;
  state_t w_next_state;

  logic [DATA_WIDTH:0]   r_mem [0:DEPTH-1];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_commit_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [DATA_WIDTH:0]   r_stage;
  logic                  r_stage_first;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;
  logic [CNT_WIDTH-1:0]  r_frame_cnt;
  logic [CNT_WIDTH-1:0]  r_drop_cnt;
  logic                  r_drop_pulse;

  logic [ADDR_WIDTH:0] w_ptr_diff;
  logic                w_full;
  logic                w_flag_ok;
  logic                w_err;
  logic                w_stage_load;
  logic                w_wr_en;
  logic                w_commit;
  logic                w_rewind;
  logic                w_fifo_has;
  logic                w_load;

  // Pointers carry one extra bit, so a distance of DEPTH (MSB set) means full.
  assign w_ptr_diff = r_wr_ptr - r_rd_ptr;
  assign w_full     = w_ptr_diff[ADDR_WIDTH];
  // A staged word must be flagged exactly when it is the head or the tail.
  assign w_flag_ok  = (r_stage[DATA_WIDTH] == (i_data_wr ? r_stage_first : 1'b1));
  assign w_err      = !w_flag_ok || w_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_SKIP;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_SKIP: if (!i_data_wr) w_next_state = S_IDLE;
      S_IDLE: if (i_data_wr) w_next_state = S_RECV;
      S_RECV: begin
        if (!i_data_wr)  w_next_state = S_IDLE;
        else if (w_err)  w_next_state = S_DROP;
      end
      S_DROP: if (!i_data_wr) w_next_state = S_IDLE;
      default: w_next_state = S_SKIP;
    endcase
  end

  always_comb begin
    w_stage_load = 1'b0;
    w_wr_en      = 1'b0;
    w_commit     = 1'b0;
    w_rewind     = 1'b0;
    case (r_state)
      S_IDLE: w_stage_load = i_data_wr;
      S_RECV: begin
        w_stage_load = i_data_wr;
        w_wr_en      = !w_full;
        w_commit     = !i_data_wr && !w_err;
        w_rewind     = !i_data_wr && w_err;
      end
      S_DROP: w_rewind = !i_data_wr;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {!i_data_wr, r_stage[DATA_WIDTH-1:0]};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage       <= '0;
      r_stage_first <= 1'b0;
      r_wr_ptr      <= '0;
      r_commit_ptr  <= '0;
      r_frame_cnt   <= '0;
      r_drop_cnt    <= '0;
      r_drop_pulse  <= 1'b0;
    end else begin
      r_drop_pulse <= w_rewind;
      if (w_stage_load) begin
        r_stage       <= iv_data;
        r_stage_first <= (r_state == S_IDLE);
      end
      if (w_rewind) begin
        r_wr_ptr <= r_commit_ptr;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_ONE;
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_commit) begin
        r_commit_ptr <= r_wr_ptr + PTR_ONE;
        if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + CNT_ONE;
      end
    end
  end

  // Output register refills whenever it is empty or being consumed this cycle.
  assign w_fifo_has = (r_rd_ptr != r_commit_ptr);
  assign w_load     = w_fifo_has && (!r_valid || i_data_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else if (w_load) begin
      r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_data   <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]][DATA_WIDTH-1:0];
      r_last   <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]][DATA_WIDTH];
      r_valid  <= 1'b1;
    end else if (r_valid && i_data_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign ov_data      = r_data;
  assign o_data_valid = r_valid;
  assign o_data_last  = r_last;
  assign ov_frame_cnt = r_frame_cnt;
  assign ov_drop_cnt  = r_drop_cnt;
  assign o_drop_pulse = r_drop_pulse;

endmodule

// File: tb/tb_htd_frame_rx.sv
// Directed bench for htd_frame_rx using a small FIFO (ADDR_WIDTH=3) so that
// overflow and exact-fit frames are cheap to exercise.
module tb_htd_frame_rx;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          rstN;
  logic [DW:0]   dataIn;
  logic          dataWr;
  logic [DW-1:0] dataOut;
  logic          dataValid;
  logic          dataLast;
  logic          dataReady;
  logic [CW-1:0] frameCnt;
  logic [CW-1:0] dropCnt;
  logic          dropPulse;

  int checks = 0;
  int failures = 0;

  logic [DW:0]   outQ [$];
  logic [DW:0]   frameBuf [0:15];
  logic [DW:0]   expBuf [0:15];
  logic          readyPat [0:3];
  logic [DW+1:0] held;
  logic          heldReady;

  htd_frame_rx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .i_clk        (clock),
    .i_rst_n      (rstN),
    .iv_data      (dataIn),
    .i_data_wr    (dataWr),
    .ov_data      (dataOut),
    .o_data_valid (dataValid),
    .o_data_last  (dataLast),
    .i_data_ready (dataReady),
    .ov_frame_cnt (frameCnt),
    .ov_drop_cnt  (dropCnt),
    .o_drop_pulse (dropPulse)
  );

  always #5 clock = ~clock;

  // Inputs only change just after a rising edge, so a word seen valid and
  // ready at the falling edge is the one transferred at the next rising edge.
  always @(negedge clock) begin
    if (rstN && dataValid && dataReady) outQ.push_back({dataLast, dataOut});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives frameBuf[0..n-1] as one contiguous run, then one idle cycle;
  // returns 1ns after edge E (the edge that samples the frame end).
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      dataIn = frameBuf[i];
      dataWr = 1'b1;
      @(posedge clock); #1;
    end
    dataWr = 1'b0;
    dataIn = '0;
    @(posedge clock); #1;
  endtask

  task automatic waitWords(input int n);
    int c = 0;
    while (outQ.size() < n && c < 40) begin
      @(posedge clock); #1;
      c++;
    end
    repeat (3) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic checkWords(input string tag, input int n);
    logic [31:0] got;
    checkOutput({tag, "_count"}, 32'(outQ.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < outQ.size()) ? 32'(outQ[i]) : 32'hDEAD;
      checkOutput($sformatf("%s_w%0d", tag, i), got, 32'(expBuf[i]));
    end
  endtask

  initial begin
    rstN = 1'b0;
    dataWr = 1'b0;
    dataIn = '0;
    dataReady = 1'b1;
    readyPat[0] = 1'b1; readyPat[1] = 1'b0; readyPat[2] = 1'b0; readyPat[3] = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_data",  32'(dataOut),   32'h0);
    checkOutput("rst_valid", 32'(dataValid), 32'h0);
    checkOutput("rst_last",  32'(dataLast),  32'h0);
    checkOutput("rst_fcnt",  32'(frameCnt),  32'h0);
    checkOutput("rst_dcnt",  32'(dropCnt),   32'h0);
    checkOutput("rst_pulse", 32'(dropPulse), 32'h0);
    rstN = 1'b1;
    @(posedge clock); #1;

    // Well-formed 4-word frame, valid appears one edge after E
    outQ.delete();
    frameBuf[0] = 9'h111; frameBuf[1] = 9'h022; frameBuf[2] = 9'h033; frameBuf[3] = 9'h144;
    applyStimulus(4);
    checkOutput("t1_fcnt_at_e",  32'(frameCnt),  32'd1);
    checkOutput("t1_valid_at_e", 32'(dataValid), 32'h0);
    @(posedge clock); #1;
    checkOutput("t1_valid_e1", 32'(dataValid), 32'h1);
    checkOutput("t1_data_e1",  32'(dataOut),   32'h11);
    waitWords(4);
    expBuf[0] = 9'h011; expBuf[1] = 9'h022; expBuf[2] = 9'h033; expBuf[3] = 9'h144;
    checkWords("t1", 4);

    // Single-word frame
    outQ.delete();
    frameBuf[0] = 9'h1A5;
    applyStimulus(1);
    waitWords(1);
    expBuf[0] = 9'h1A5;
    checkWords("t2", 1);
    checkOutput("t2_fcnt", 32'(frameCnt), 32'd2);

    // Middle flag error drops the frame with a single pulse
    outQ.delete();
    frameBuf[0] = 9'h1F1; frameBuf[1] = 9'h1F2; frameBuf[2] = 9'h0F3; frameBuf[3] = 9'h1F4;
    applyStimulus(4);
    checkOutput("t3_pulse_hi", 32'(dropPulse), 32'h1);
    checkOutput("t3_dcnt",     32'(dropCnt),   32'd1);
    @(posedge clock); #1;
    checkOutput("t3_pulse_lo", 32'(dropPulse), 32'h0);
    waitWords(1);
    checkOutput("t3_no_output", 32'(outQ.size()), 32'd0);
    checkOutput("t3_fcnt",      32'(frameCnt),    32'd2);

    // 9-word frame overflows the 8-entry FIFO; an 8-word frame then fits
    outQ.delete();
    frameBuf[0] = 9'h180;
    for (int i = 1; i < 8; i++) frameBuf[i] = 9'(9'h080 + i);
    frameBuf[8] = 9'h188;
    applyStimulus(9);
    checkOutput("t4_dcnt",  32'(dropCnt),   32'd2);
    checkOutput("t4_pulse", 32'(dropPulse), 32'h1);
    frameBuf[0] = 9'h190;
    for (int i = 1; i < 7; i++) frameBuf[i] = 9'(9'h090 + i);
    frameBuf[7] = 9'h197;
    applyStimulus(8);
    checkOutput("t4_fcnt", 32'(frameCnt), 32'd3);
    waitWords(8);
    for (int i = 0; i < 7; i++) expBuf[i] = 9'(9'h090 + i);
    expBuf[7] = 9'h197;
    checkWords("t4", 8);

    // Two 3-word frames drained under a 1,0,0,1 ready pattern
    outQ.delete();
    dataReady = 1'b0;
    frameBuf[0] = 9'h1B1; frameBuf[1] = 9'h0B2; frameBuf[2] = 9'h1B3;
    applyStimulus(3);
    frameBuf[0] = 9'h1C1; frameBuf[1] = 9'h0C2; frameBuf[2] = 9'h1C3;
    applyStimulus(3);
    checkOutput("t5_fcnt", 32'(frameCnt), 32'd5);
    @(posedge clock); #1;
    for (int k = 0; k < 32 && outQ.size() < 6; k++) begin
      dataReady = readyPat[k % 4];
      held = {dataValid, dataLast, dataOut};
      heldReady = dataReady;
      @(posedge clock); #1;
      if (!heldReady && held[DW+1])
        checkOutput($sformatf("t5_hold%0d", k), 32'({dataValid, dataLast, dataOut}), 32'(held));
    end
    dataReady = 1'b1;
    waitWords(6);
    expBuf[0] = 9'h0B1; expBuf[1] = 9'h0B2; expBuf[2] = 9'h1B3;
    expBuf[3] = 9'h0C1; expBuf[4] = 9'h0C2; expBuf[5] = 9'h1C3;
    checkWords("t5", 6);

    // Reset mid-frame; the run still active at release must be ignored
    outQ.delete();
    dataIn = 9'h1E1;
    dataWr = 1'b1;
    @(posedge clock); #1;
    rstN = 1'b0;
    #1;
    checkOutput("t6_async_fcnt", 32'(frameCnt), 32'd0);
    dataIn = 9'h0E2;
    repeat (2) @(posedge clock);
    #1;
    rstN = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    dataIn = 9'h1E3;
    dataWr = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("t6_fcnt",  32'(frameCnt),  32'd0);
    checkOutput("t6_dcnt",  32'(dropCnt),   32'd0);
    checkOutput("t6_pulse", 32'(dropPulse), 32'h0);
    checkOutput("t6_no_output", 32'(outQ.size()), 32'd0);
    frameBuf[0] = 9'h1D1; frameBuf[1] = 9'h1D2;
    applyStimulus(2);
    waitWords(2);
    expBuf[0] = 9'h0D1; expBuf[1] = 9'h1D2;
    checkWords("t6", 2);
    checkOutput("t6_fcnt_after", 32'(frameCnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
